// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core load/store path and a DMA/debug port.
// Define DMEM_ARB_STATS_EN to add saturating grant/stall statistics counters.
module dmem_arbiter #(
    parameter int unsigned DMEM_ADDR_WIDTH = 12,
    parameter int unsigned DMEM_WORD_WIDTH = 16,
    parameter int unsigned WAIT_CNT_WIDTH  = 4,
    parameter int unsigned MAX_DMA_WAIT    = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_core_load,
    input  logic                       in_core_store,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_core_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_core_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_core_wr_word,
    output logic                       out_core_stall,
    output logic                       out_core_rvalid,
    output logic [DMEM_WORD_WIDTH-1:0] out_core_rdata,
    input  logic                       in_dma_req,
    input  logic                       in_dma_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dma_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dma_wdata,
    output logic                       out_dma_ack,
    output logic                       out_dma_rvalid,
    output logic [DMEM_WORD_WIDTH-1:0] out_dma_rdata,
    output logic                       out_mem_en,
    output logic                       out_mem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] out_mem_addr,
    output logic [DMEM_WORD_WIDTH-1:0] out_mem_wdata,
    input  logic [DMEM_WORD_WIDTH-1:0] in_mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]                out_stat_core_grants,
    output logic [15:0]                out_stat_dma_grants,
    output logic [15:0]                out_stat_stalls
`endif
);

    localparam int unsigned STAT_WIDTH = 16;

    typedef enum logic {
        S_NORMAL    = 1'b0,
        S_DMA_FORCE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    state_t                    state;
    state_t                    state_next;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_next;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_inc;
    owner_t                    rd_owner_ff;
    owner_t                    rd_owner_next;

    logic core_req;
    logic core_grant;
    logic dma_grant;
    logic stall;

    // Grant decode: core has priority except during the single forced DMA slot.
    always_comb begin
        core_req   = in_core_load | in_core_store;
        core_grant = core_req && (state == S_NORMAL);
        dma_grant  = in_dma_req && ((state == S_DMA_FORCE) || !core_req);
        stall      = core_req && (state == S_DMA_FORCE);
    end

    // Starvation counter and next-state logic.
    always_comb begin
        wait_cnt_inc  = wait_cnt + WAIT_CNT_WIDTH'(1);
        wait_cnt_next = '0;
        state_next    = S_NORMAL;
        rd_owner_next = OWN_NONE;
        if (in_dma_req && !dma_grant) begin
            wait_cnt_next = wait_cnt_inc;
            if (wait_cnt_inc == WAIT_CNT_WIDTH'(MAX_DMA_WAIT)) begin
                state_next = S_DMA_FORCE;
            end
        end
        if (core_grant && !in_core_store) begin
            rd_owner_next = OWN_CORE;
        end else if (dma_grant && !in_dma_we) begin
            rd_owner_next = OWN_DMA;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_NORMAL;
            wait_cnt    <= '0;
            rd_owner_ff <= OWN_NONE;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            rd_owner_ff <= rd_owner_next;
        end
    end

    // Memory port and response outputs; everything is held at zero while reset is asserted.
    always_comb begin
        out_core_stall  = 1'b0;
        out_core_rvalid = 1'b0;
        out_core_rdata  = '0;
        out_dma_ack     = 1'b0;
        out_dma_rvalid  = 1'b0;
        out_dma_rdata   = '0;
        out_mem_en      = 1'b0;
        out_mem_we      = 1'b0;
        out_mem_addr    = '0;
        out_mem_wdata   = '0;
        if (!reset) begin
            out_core_stall = stall;
            out_dma_ack    = dma_grant;
            if (core_grant) begin
                out_mem_en    = 1'b1;
                out_mem_we    = in_core_store;
                out_mem_addr  = in_core_store ? in_core_wr_addr : in_core_rd_addr;
                out_mem_wdata = in_core_wr_word;
            end else if (dma_grant) begin
                out_mem_en    = 1'b1;
                out_mem_we    = in_dma_we;
                out_mem_addr  = in_dma_addr;
                out_mem_wdata = in_dma_wdata;
            end
            if (rd_owner_ff == OWN_CORE) begin
                out_core_rvalid = 1'b1;
                out_core_rdata  = in_mem_rdata;
            end
            if (rd_owner_ff == OWN_DMA) begin
                out_dma_rvalid = 1'b1;
                out_dma_rdata  = in_mem_rdata;
            end
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] stat_core_grants;
    logic [STAT_WIDTH-1:0] stat_dma_grants;
    logic [STAT_WIDTH-1:0] stat_stalls;

    // Saturating event counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_core_grants <= '0;
            stat_dma_grants  <= '0;
            stat_stalls      <= '0;
        end else begin
            if (core_grant && (stat_core_grants != '1)) begin
                stat_core_grants <= stat_core_grants + STAT_WIDTH'(1);
            end
            if (dma_grant && (stat_dma_grants != '1)) begin
                stat_dma_grants <= stat_dma_grants + STAT_WIDTH'(1);
            end
            if (stall && (stat_stalls != '1)) begin
                stat_stalls <= stat_stalls + STAT_WIDTH'(1);
            end
        end
    end

    assign out_stat_core_grants = stat_core_grants;
    assign out_stat_dma_grants  = stat_dma_grants;
    assign out_stat_stalls      = stat_stalls;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (default parameters).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        in_core_load;
    logic        in_core_store;
    logic [11:0] in_core_rd_addr;
    logic [11:0] in_core_wr_addr;
    logic [15:0] in_core_wr_word;
    logic        out_core_stall;
    logic        out_core_rvalid;
    logic [15:0] out_core_rdata;
    logic        in_dma_req;
    logic        in_dma_we;
    logic [11:0] in_dma_addr;
    logic [15:0] in_dma_wdata;
    logic        out_dma_ack;
    logic        out_dma_rvalid;
    logic [15:0] out_dma_rdata;
    logic        out_mem_en;
    logic        out_mem_we;
    logic [11:0] out_mem_addr;
    logic [15:0] out_mem_wdata;
    logic [15:0] in_mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] out_stat_core_grants;
    logic [15:0] out_stat_dma_grants;
    logic [15:0] out_stat_stalls;
`endif

    int checks;
    int failures;

    dmem_arbiter dut (
        .clock           (clock),
        .reset           (reset),
        .in_core_load    (in_core_load),
        .in_core_store   (in_core_store),
        .in_core_rd_addr (in_core_rd_addr),
        .in_core_wr_addr (in_core_wr_addr),
        .in_core_wr_word (in_core_wr_word),
        .out_core_stall  (out_core_stall),
        .out_core_rvalid (out_core_rvalid),
        .out_core_rdata  (out_core_rdata),
        .in_dma_req      (in_dma_req),
        .in_dma_we       (in_dma_we),
        .in_dma_addr     (in_dma_addr),
        .in_dma_wdata    (in_dma_wdata),
        .out_dma_ack     (out_dma_ack),
        .out_dma_rvalid  (out_dma_rvalid),
        .out_dma_rdata   (out_dma_rdata),
        .out_mem_en      (out_mem_en),
        .out_mem_we      (out_mem_we),
        .out_mem_addr    (out_mem_addr),
        .out_mem_wdata   (out_mem_wdata),
        .in_mem_rdata    (in_mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .out_stat_core_grants (out_stat_core_grants),
        .out_stat_dma_grants  (out_stat_dma_grants),
        .out_stat_stalls      (out_stat_stalls)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(negedge clock);
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        in_core_load    = 1'b0;
        in_core_store   = 1'b0;
        in_core_rd_addr = '0;
        in_core_wr_addr = '0;
        in_core_wr_word = '0;
        in_dma_req      = 1'b0;
        in_dma_we       = 1'b0;
        in_dma_addr     = '0;
        in_dma_wdata    = '0;
        in_mem_rdata    = '0;

        // Reset state
        next_cycle();
        next_cycle();
        #1;
        chk("rst_mem_en", 32'(out_mem_en), 32'd0);
        chk("rst_ack", 32'(out_dma_ack), 32'd0);
        chk("rst_stall", 32'(out_core_stall), 32'd0);
        chk("rst_core_rvalid", 32'(out_core_rvalid), 32'd0);
        chk("rst_dma_rvalid", 32'(out_dma_rvalid), 32'd0);
        next_cycle();
        reset = 1'b0;
        #1;
        chk("idle_mem_en", 32'(out_mem_en), 32'd0);
        chk("idle_addr", 32'(out_mem_addr), 32'd0);

        // Core load 0x010, memory returns 0xBEEF
        next_cycle();
        in_core_load    = 1'b1;
        in_core_rd_addr = 12'h010;
        #1;
        chk("ld_mem_en", 32'(out_mem_en), 32'd1);
        chk("ld_mem_we", 32'(out_mem_we), 32'd0);
        chk("ld_mem_addr", 32'(out_mem_addr), 32'h010);
        chk("ld_stall", 32'(out_core_stall), 32'd0);
        next_cycle();
        in_core_load = 1'b0;
        in_mem_rdata = 16'hBEEF;
        #1;
        chk("ld_rvalid", 32'(out_core_rvalid), 32'd1);
        chk("ld_rdata", 32'(out_core_rdata), 32'hBEEF);
        chk("ld_dma_rvalid", 32'(out_dma_rvalid), 32'd0);
        chk("ld_dma_rdata", 32'(out_dma_rdata), 32'd0);

        // DMA write while core idle
        next_cycle();
        in_mem_rdata = 16'h0000;
        in_dma_req   = 1'b1;
        in_dma_we    = 1'b1;
        in_dma_addr  = 12'h3FF;
        in_dma_wdata = 16'h1234;
        #1;
        chk("dw_ack", 32'(out_dma_ack), 32'd1);
        chk("dw_mem_en", 32'(out_mem_en), 32'd1);
        chk("dw_mem_we", 32'(out_mem_we), 32'd1);
        chk("dw_addr", 32'(out_mem_addr), 32'h3FF);
        chk("dw_wdata", 32'(out_mem_wdata), 32'h1234);
        next_cycle();
        in_dma_req = 1'b0;
        in_dma_we  = 1'b0;
        #1;
        chk("dw_no_rvalid", 32'(out_dma_rvalid), 32'd0);
        chk("dw_idle", 32'(out_mem_en), 32'd0);

        // Core loads every cycle, DMA read held: forced slot in cycle 4
        next_cycle();
        in_core_load    = 1'b1;
        in_core_rd_addr = 12'h020;
        in_dma_req      = 1'b1;
        in_dma_addr     = 12'h055;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("starve_ack_c%0d", i), 32'(out_dma_ack), 32'd0);
            chk($sformatf("starve_stall_c%0d", i), 32'(out_core_stall), 32'd0);
            chk($sformatf("starve_addr_c%0d", i), 32'(out_mem_addr), 32'h020);
            next_cycle();
        end
        #1;
        chk("force_ack", 32'(out_dma_ack), 32'd1);
        chk("force_stall", 32'(out_core_stall), 32'd1);
        chk("force_addr", 32'(out_mem_addr), 32'h055);
        chk("force_we", 32'(out_mem_we), 32'd0);
        chk("force_core_rvalid", 32'(out_core_rvalid), 32'd1);
        next_cycle();
        in_dma_req   = 1'b0;
        in_mem_rdata = 16'h5A5A;
        #1;
        chk("post_dma_rvalid", 32'(out_dma_rvalid), 32'd1);
        chk("post_dma_rdata", 32'(out_dma_rdata), 32'h5A5A);
        chk("post_core_rvalid", 32'(out_core_rvalid), 32'd0);
        chk("post_core_rdata", 32'(out_core_rdata), 32'd0);
        chk("post_stall", 32'(out_core_stall), 32'd0);
        chk("post_core_addr", 32'(out_mem_addr), 32'h020);
        next_cycle();
        in_core_load = 1'b0;
        in_mem_rdata = 16'h0F0F;
        #1;
        chk("post2_core_rvalid", 32'(out_core_rvalid), 32'd1);
        chk("post2_core_rdata", 32'(out_core_rdata), 32'h0F0F);

        // Load and store together: store wins, load dropped
        next_cycle();
        in_mem_rdata    = 16'h0000;
        in_core_load    = 1'b1;
        in_core_store   = 1'b1;
        in_core_rd_addr = 12'h001;
        in_core_wr_addr = 12'h002;
        in_core_wr_word = 16'hAAAA;
        #1;
        chk("ls_we", 32'(out_mem_we), 32'd1);
        chk("ls_addr", 32'(out_mem_addr), 32'h002);
        chk("ls_wdata", 32'(out_mem_wdata), 32'hAAAA);
        chk("ls_stall", 32'(out_core_stall), 32'd0);
        next_cycle();
        in_core_load  = 1'b0;
        in_core_store = 1'b0;
        in_mem_rdata  = 16'h7777;
        #1;
        chk("ls_no_rvalid", 32'(out_core_rvalid), 32'd0);

        // Core read then DMA read back-to-back
        next_cycle();
        in_core_load    = 1'b1;
        in_core_rd_addr = 12'h100;
        #1;
        chk("alt_core_addr", 32'(out_mem_addr), 32'h100);
        next_cycle();
        in_core_load = 1'b0;
        in_dma_req   = 1'b1;
        in_dma_we    = 1'b0;
        in_dma_addr  = 12'h200;
        in_mem_rdata = 16'h1111;
        #1;
        chk("alt_core_rvalid", 32'(out_core_rvalid), 32'd1);
        chk("alt_core_rdata", 32'(out_core_rdata), 32'h1111);
        chk("alt_dma_ack", 32'(out_dma_ack), 32'd1);
        chk("alt_dma_addr", 32'(out_mem_addr), 32'h200);
        chk("alt_dma_rvalid0", 32'(out_dma_rvalid), 32'd0);
        next_cycle();
        in_dma_req   = 1'b0;
        in_mem_rdata = 16'h2222;
        #1;
        chk("alt_dma_rvalid", 32'(out_dma_rvalid), 32'd1);
        chk("alt_dma_rdata", 32'(out_dma_rdata), 32'h2222);
        chk("alt_core_rvalid1", 32'(out_core_rvalid), 32'd0);
        chk("alt_core_rdata1", 32'(out_core_rdata), 32'd0);

        // Reset with a core read in flight
        next_cycle();
        in_mem_rdata    = 16'h0000;
        in_core_load    = 1'b1;
        in_core_rd_addr = 12'h030;
        #1;
        chk("rf_issue", 32'(out_mem_en), 32'd1);
        next_cycle();
        in_core_load = 1'b0;
        reset        = 1'b1;
        in_mem_rdata = 16'h3333;
        #1;
        chk("rf_rvalid_in_rst", 32'(out_core_rvalid), 32'd0);
        chk("rf_rdata_in_rst", 32'(out_core_rdata), 32'd0);
        chk("rf_mem_en_in_rst", 32'(out_mem_en), 32'd0);
        next_cycle();
        reset = 1'b0;
        #1;
        chk("rf_rvalid_after", 32'(out_core_rvalid), 32'd0);
        chk("rf_idle_after", 32'(out_mem_en), 32'd0);

        // Denied 3 cycles, dropped, re-raised: full count restarts
        next_cycle();
        in_mem_rdata    = 16'h0000;
        in_core_load    = 1'b1;
        in_core_rd_addr = 12'h040;
        in_dma_req      = 1'b1;
        in_dma_addr     = 12'h066;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("drop_ack_c%0d", i), 32'(out_dma_ack), 32'd0);
            next_cycle();
        end
        in_dma_req = 1'b0;
        #1;
        chk("drop_gap_ack", 32'(out_dma_ack), 32'd0);
        next_cycle();
        in_dma_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("restart_ack_c%0d", i), 32'(out_dma_ack), 32'd0);
            chk($sformatf("restart_stall_c%0d", i), 32'(out_core_stall), 32'd0);
            next_cycle();
        end
        #1;
        chk("restart_force_ack", 32'(out_dma_ack), 32'd1);
        chk("restart_force_stall", 32'(out_core_stall), 32'd1);
        chk("restart_force_addr", 32'(out_mem_addr), 32'h066);
        next_cycle();
        in_dma_req   = 1'b0;
        in_core_load = 1'b0;
        #1;
        chk("restart_done_stall", 32'(out_core_stall), 32'd0);
        chk("restart_dma_rvalid", 32'(out_dma_rvalid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
